hilo_acc_file: RTL
==================

// Module: hilo_acc_file
// PURPOSE
//  Next-generation HI/LO register file for the MEM stage. It replaces the single-port hilo pair.
//  - Parametrised data width.
//  - NUM_WP write ports, for dual-issue commit.
//  - Per-half write enables, with same-cycle forwarding of the newest value.
//  - Two-cycle accumulate engine (MADD/MADDU/MSUB/MSUBU): adds/subtracts a 2*DATA_W product
//    into {HI,LO}, and can be cancelled by flush.
//  Sits after the multiplier; feeds MFHI/MFLO and the multiply-accumulate path.
// PARAMETERS
//  DATA_W  32  width of HI and of LO
//  NUM_WP  2   number of direct write ports; a higher index is the younger instruction
// PORTS
//  clk_i         in   1             clock; all state updates on posedge
//  rst_i         in   1             reset, asynchronous, active-low
//  wr_hi_i       in   NUM_WP        per-port HI write enable
//  wr_hi_data_i  in   NUM_WP*DATA_W per-port HI write data; port k occupies [k*DATA_W +: DATA_W]
//  wr_lo_i       in   NUM_WP        per-port LO write enable
//  wr_lo_data_i  in   NUM_WP*DATA_W per-port LO write data; same packing as HI
//  acc_valid_i   in   1             start accumulate; sampled only in IDLE
//  acc_op_i      in   1             hilo_pkg::acc_op_e: ACC_ADD=0, ACC_SUB=1
//  acc_prod_i    in   2*DATA_W      product operand; sampled with acc_valid_i
//  flush_i       in   1             cancel in-flight accumulate
//  hi_o          out  DATA_W        forwarded HI view
//  lo_o          out  DATA_W        forwarded LO view
//  busy_o        out  1             high while in ACC_HI; issue stalls on it
//  acc_done_o    out  1             high in the cycle the accumulate result commits
// BEHAVIOUR
//  Reset (rst_i=0, async)
//   - hi_reg and lo_reg clear to 0; state goes to IDLE.
//   - busy_o=0, acc_done_o=0.
//   - hi_o and lo_o are forced to 0 while reset is held.
//   - Reset mid-accumulate aborts it with no commit.
//  Direct writes
//   - Each half is independent. The highest-index port with its enable set wins.
//   - Write takes effect at the next posedge.
//   - Write is forwarded combinationally to hi_o/lo_o in the same cycle (0-cycle bypass).
//   - No enable set: the output shows the register.
//  Accumulate FSM (hilo_pkg::hilo_state_e: IDLE, ACC_HI)
//   - IDLE & acc_valid_i & !flush_i:
//     - base = forwarded {hi_o,lo_o}, i.e. this cycle's direct writes count as older.
//     - lo_sum = base_lo +/- prod[DATA_W-1:0].
//     - Latch lo_sum, carry/borrow, prod_hi, base_hi, op.
//     - Transition to ACC_HI. Registers are not yet updated.
//   - IDLE & acc_valid_i & flush_i: request ignored; stay IDLE.
//   - ACC_HI: busy_o=1 and hi_new = base_hi +/- prod_hi +/- carry, with arithmetic modulo 2^(2*DATA_W).
//     - ADD: carry = unsigned overflow of the low add.
//     - SUB: borrow = (base_lo < prod_lo).
//   - ACC_HI & !flush_i & no direct write enable:
//     - acc_done_o=1; hi_o=hi_new, lo_o=lo_sum (forwarded).
//     - Both registers commit at the posedge; go to IDLE.
//   - ACC_HI & flush_i: no commit, acc_done_o=0, outputs show registers; go to IDLE.
//   - ACC_HI & any direct write: the write is applied and forwarded; the accumulate is
//     discarded (acc_done_o=0); go to IDLE.
//  Other rules
//   - acc_valid_i in ACC_HI is ignored; the issue stage must not raise it while busy_o=1.
//   - Throughput: one accumulate every 2 cycles; back-to-back start is legal on the cycle after done.
// STRUCTURE
//  - hilo_pkg holds acc_op_e, hilo_state_e and localparam ACC_LAT=2.
//  - Sub-module hilo_half_addsub #(DATA_W): a, b, cin, sub -> sum, cout.
//    Two instances: low half (cin=0) and high half (cin=latched carry/borrow).
//  - The write-port priority mux is a generate loop in the top module.
// TESTING  (DATA_W=32, NUM_WP=2)
//  1 Hold rst_i=0 for 3 cycles, then drive port writes during reset
//    -> hi_o=lo_o=0, busy_o=0; registers remain 0 after release.
//  2 Same cycle: p0 wr_hi=0x11111111, p1 wr_hi=0x22222222, p0 wr_lo=0xAAAA0000
//    -> same cycle hi_o=0x22222222, lo_o=0xAAAA0000; held on following cycles.
//  3 hi=0, lo=0xFFFFFFFF; ADD prod=0x1
//    -> next cycle busy_o=1, acc_done_o=1, hi_o=0x1, lo_o=0x0; then IDLE.
//  4 hi=0, lo=0; SUB prod=0x1
//    -> done with hi_o=lo_o=0xFFFFFFFF (wrap).
//    hi=1, lo=0; SUB prod=1 -> hi=0, lo=0xFFFFFFFF.
//  5 hi=5, lo=7; ADD prod=0x1_00000001, flush_i in ACC_HI
//    -> no done, hi=5, lo=7, busy_o=0 next cycle.
//    Same start with p1 wr_lo=0x9 in ACC_HI -> lo=0x9, hi=5, no done.
//  6 Accumulate start, then rst_i=0 asynchronously mid-ACC_HI
//    -> outputs 0 immediately, state IDLE; after release a fresh ADD prod=3 gives lo=3.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO accumulate register file.
package hilo_pkg;

  typedef enum logic {
    AccAdd = 1'b0,
    AccSub = 1'b1
  } acc_op_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StAccHi = 1'b1
  } hilo_state_e;

  // Start-to-commit latency of an accumulate, in cycles
  localparam int unsigned ACC_LAT = 2;

endpackage

// File: rtl/hilo_acc_file_if.sv
// Bus bundle between issue/commit logic and the HI/LO file.
interface hilo_acc_file_if
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_WP = 2
);

  logic [NUM_WP-1:0]        wr_hi_i;
  logic [NUM_WP*DATA_W-1:0] wr_hi_data_i;
  logic [NUM_WP-1:0]        wr_lo_i;
  logic [NUM_WP*DATA_W-1:0] wr_lo_data_i;
  logic                     acc_valid_i;
  acc_op_e                  acc_op_i;
  logic [2*DATA_W-1:0]      acc_prod_i;
  logic                     flush_i;
  logic [DATA_W-1:0]        hi_o;
  logic [DATA_W-1:0]        lo_o;
  logic                     busy_o;
  logic                     acc_done_o;

  modport master (
    output wr_hi_i, wr_hi_data_i, wr_lo_i, wr_lo_data_i,
    output acc_valid_i, acc_op_i, acc_prod_i, flush_i,
    input  hi_o, lo_o, busy_o, acc_done_o
  );

  modport slave (
    input  wr_hi_i, wr_hi_data_i, wr_lo_i, wr_lo_data_i,
    input  acc_valid_i, acc_op_i, acc_prod_i, flush_i,
    output hi_o, lo_o, busy_o, acc_done_o
  );

endinterface

// File: rtl/hilo_half_addsub.sv
// One DATA_W-wide half of the accumulate adder. For subtract, cout_o is the borrow out.
module hilo_half_addsub #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              cout_o
);

  logic [DATA_W:0] res;

  // Extended-width add/sub: the top bit is carry (add) or borrow (sub)
  always_comb begin
    if (sub_i) begin
      res = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, cin_i};
    end else begin
      res = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
    end
  end

  assign sum_o  = res[DATA_W-1:0];
  assign cout_o = res[DATA_W];

endmodule

// File: rtl/hilo_acc_file.sv
// HI/LO register file: prioritised multi-port direct writes with 0-cycle forwarding,
// plus a two-cycle flushable multiply-accumulate engine.
module hilo_acc_file
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_WP = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  hilo_acc_file_if.slave bus
);

  hilo_state_e       state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] lo_sum_q, lo_sum_d, prod_hi_q, prod_hi_d, base_hi_q, base_hi_d;
  logic              carry_q, carry_d;
  acc_op_e           op_q, op_d;

  logic [NUM_WP-1:0] hi_win, lo_win;
  logic [DATA_W-1:0] hi_fwd, lo_fwd, hi_view, lo_view;
  logic [DATA_W-1:0] lo_add_sum, hi_new;
  logic              lo_add_cout, hi_add_cout_unused;
  logic              any_wr, done, busy;

  // A port wins its half when it is enabled and no higher (younger) port is
  for (genvar k = 0; k < NUM_WP; k++) begin : g_wp
    assign hi_win[k] = bus.wr_hi_i[k] && ((bus.wr_hi_i >> (k + 1)) == '0);
    assign lo_win[k] = bus.wr_lo_i[k] && ((bus.wr_lo_i >> (k + 1)) == '0);
  end

  // Forwarded view: winning write data, else the stored register
  always_comb begin
    hi_fwd = hi_q;
    lo_fwd = lo_q;
    for (int k = 0; k < NUM_WP; k++) begin
      if (hi_win[k]) hi_fwd = bus.wr_hi_data_i[k*DATA_W +: DATA_W];
      if (lo_win[k]) lo_fwd = bus.wr_lo_data_i[k*DATA_W +: DATA_W];
    end
  end

  assign any_wr = (|bus.wr_hi_i) || (|bus.wr_lo_i);

  hilo_half_addsub #(.DATA_W(DATA_W)) u_lo_half (
    .a_i   (lo_fwd),
    .b_i   (bus.acc_prod_i[DATA_W-1:0]),
    .cin_i (1'b0),
    .sub_i (bus.acc_op_i == AccSub),
    .sum_o (lo_add_sum),
    .cout_o(lo_add_cout)
  );

  // High half carry-out is dropped: the result wraps modulo 2^(2*DATA_W)
  hilo_half_addsub #(.DATA_W(DATA_W)) u_hi_half (
    .a_i   (base_hi_q),
    .b_i   (prod_hi_q),
    .cin_i (carry_q),
    .sub_i (op_q == AccSub),
    .sum_o (hi_new),
    .cout_o(hi_add_cout_unused)
  );

  // Next-state, operand latching and output view selection
  always_comb begin
    state_d   = state_q;
    lo_sum_d  = lo_sum_q;
    carry_d   = carry_q;
    prod_hi_d = prod_hi_q;
    base_hi_d = base_hi_q;
    op_d      = op_q;
    hi_d      = hi_fwd;
    lo_d      = lo_fwd;
    hi_view   = hi_fwd;
    lo_view   = lo_fwd;
    done      = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.acc_valid_i && !bus.flush_i) begin
          state_d   = StAccHi;
          lo_sum_d  = lo_add_sum;
          carry_d   = lo_add_cout;
          prod_hi_d = bus.acc_prod_i[2*DATA_W-1:DATA_W];
          base_hi_d = hi_fwd;
          op_d      = bus.acc_op_i;
        end
      end
      StAccHi: begin
        busy    = 1'b1;
        state_d = StIdle;
        // A flush or any younger direct write discards the accumulate
        if (!bus.flush_i && !any_wr) begin
          done    = 1'b1;
          hi_view = hi_new;
          lo_view = lo_sum_q;
          hi_d    = hi_new;
          lo_d    = lo_sum_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Architectural and accumulate-pipeline state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      lo_q      <= '0;
      lo_sum_q  <= '0;
      carry_q   <= 1'b0;
      prod_hi_q <= '0;
      base_hi_q <= '0;
      op_q      <= AccAdd;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      lo_sum_q  <= lo_sum_d;
      carry_q   <= carry_d;
      prod_hi_q <= prod_hi_d;
      base_hi_q <= base_hi_d;
      op_q      <= op_d;
    end
  end

  // Views are forced to zero while reset is held, even with writes pending
  assign bus.hi_o       = rst_i ? hi_view : '0;
  assign bus.lo_o       = rst_i ? lo_view : '0;
  assign bus.busy_o     = busy;
  assign bus.acc_done_o = done;

endmodule
